// File: rtl/shift_add_pkg.sv
// State encodings and state type for the shift-and-add multiplier sequencer.
package shift_add_pkg;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_LOAD  = 3'd1;
  localparam logic [2:0] ENC_EVAL  = 3'd2;
  localparam logic [2:0] ENC_ADD   = 3'd3;
  localparam logic [2:0] ENC_SHIFT = 3'd4;
  localparam logic [2:0] ENC_DONE  = 3'd5;

  // S_ prefix keeps state names clear of the DONE port and ST input.
  typedef enum logic [2:0] {
    S_IDLE  = ENC_IDLE,
    S_LOAD  = ENC_LOAD,
    S_EVAL  = ENC_EVAL,
    S_ADD   = ENC_ADD,
    S_SHIFT = ENC_SHIFT,
    S_DONE  = ENC_DONE
  } state_t;

endpackage

// File: rtl/shift_add_ctrl_iter_counter.sv
// Iteration counter: cleared on load, advanced once per shift, saturates at WIDTH-1.
module iter_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  // Count register; the hold at LAST_VAL keeps cnt within 0..WIDTH-1 even if inc is misused.
  always_ff @(posedge clk) begin
    if (rst)                          cnt <= '0;
    else if (clr)                     cnt <= '0;
    else if (inc && cnt != LAST_VAL)  cnt <= cnt + 1'b1;
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/shift_add_ctrl.sv
// Moore sequencer for an N-bit shift-and-add multiplier datapath.
module shift_add_ctrl
  import shift_add_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic ST,
  input  logic M,
  output logic LD,
  output logic AD,
  output logic SH,
  output logic DONE,
  output logic BUSY
);

  state_t state, nxt;
  logic   last;
  logic   cnt_clr;
  logic   cnt_inc;

  iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (CLK),
    .rst  (RST),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (last)
  );

  // State register; reset wins over everything, including mid-operation.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic; ST is only looked at in IDLE/DONE, M only in EVAL.
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:  nxt = ST ? S_LOAD : S_IDLE;
      S_LOAD:  nxt = S_EVAL;
      S_EVAL:  nxt = M ? S_ADD : S_SHIFT;
      S_ADD:   nxt = S_SHIFT;
      S_SHIFT: nxt = last ? S_DONE : S_EVAL;
      S_DONE:  nxt = ST ? S_DONE : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Output decode: pure function of state, so LD/AD/SH are one-hot or zero by construction.
  always_comb begin
    LD      = (state == S_LOAD);
    AD      = (state == S_ADD);
    SH      = (state == S_SHIFT);
    DONE    = (state == S_DONE);
    BUSY    = (state == S_LOAD) || (state == S_EVAL) ||
              (state == S_ADD)  || (state == S_SHIFT);
    cnt_clr = (state == S_LOAD);
    cnt_inc = (state == S_SHIFT) && !last;
  end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Directed bench: drives the sequencer against a small multiplier datapath model.
module tb_shift_add_ctrl;

  logic CLK = 1'b0;
  logic RST, ST, M;
  logic LD, AD, SH, DONE, BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  // Datapath model: carry:accumulator, multiplicand, multiplier shift register.
  logic [4:0] ca;
  logic [3:0] b, q;
  logic [3:0] op_mp, op_mc;
  logic       m_junk;
  logic       in_eval;

  always #5 CLK = ~CLK;

  shift_add_ctrl #(.WIDTH(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ST   (ST),
    .M    (M),
    .LD   (LD),
    .AD   (AD),
    .SH   (SH),
    .DONE (DONE),
    .BUSY (BUSY)
  );

  // EVAL is the only busy cycle with no datapath strobe; elsewhere M carries junk.
  assign in_eval = BUSY && !LD && !AD && !SH;
  assign M       = in_eval ? q[0] : m_junk;

  always @(posedge CLK) begin
    if (LD) begin
      ca <= '0;
      b  <= op_mc;
      q  <= op_mp;
    end else if (AD) begin
      ca <= {1'b0, ca[3:0]} + {1'b0, b};
    end else if (SH) begin
      {ca, q} <= {ca, q} >> 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One multiply: ST pulse (or hold), count strobes until DONE, check timing and product.
  task automatic run_op(input string tag, input logic [3:0] mp, input logic [3:0] mc,
                        input bit hold, input bit wiggle, input int exp_cyc,
                        input int exp_nad, input logic [7:0] exp_prod);
    int cyc, nld, nad, nsh, viol;
    logic [3:0] adpat;
    bit ad_since;
    op_mp = mp; op_mc = mc; m_junk = wiggle;
    cyc = 0; nld = 0; nad = 0; nsh = 0; viol = 0; adpat = '0; ad_since = 0;
    @(negedge CLK); ST = 1'b1;
    @(negedge CLK);
    chk({tag, " ld_after_st"}, {31'b0, LD}, 1);
    nld = LD ? 1 : 0;
    ST = hold;
    while (!DONE && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (wiggle) ST = cyc[0];
      if (int'(LD) + int'(AD) + int'(SH) > 1) viol++;
      if (LD) nld++;
      if (AD) begin nad++; ad_since = 1; end
      if (SH) begin
        if (nsh < 4) adpat[nsh] = ad_since;
        nsh++;
        ad_since = 0;
      end
    end
    chk({tag, " cycles"}, cyc, exp_cyc);
    chk({tag, " ld_count"}, nld, 1);
    chk({tag, " ad_count"}, nad, exp_nad);
    chk({tag, " sh_count"}, nsh, 4);
    chk({tag, " ad_order"}, {28'b0, adpat}, {28'b0, mp});
    chk({tag, " onehot"}, viol, 0);
    chk({tag, " busy_at_done"}, {31'b0, BUSY}, 0);
    chk({tag, " product"}, {24'b0, ca[3:0], q}, {24'b0, exp_prod});
    if (hold) begin
      repeat (3) @(negedge CLK);
      chk({tag, " done_held"}, {30'b0, DONE, LD}, 32'b10);
    end
    ST = 1'b0;
    @(negedge CLK);
    chk({tag, " idle_after_st_low"}, {27'b0, LD, AD, SH, DONE, BUSY}, 0);
    repeat (2) @(negedge CLK);
    chk({tag, " no_restart"}, {27'b0, LD, AD, SH, DONE, BUSY}, 0);
    m_junk = 1'b0;
  endtask

  initial begin
    int nsh, guard;
    RST = 1'b1; ST = 1'b1; m_junk = 1'b0; op_mp = '0; op_mc = '0;

    // Reset held two cycles with ST high.
    @(negedge CLK);
    chk("rst cyc1", {27'b0, LD, AD, SH, DONE, BUSY}, 0);
    @(negedge CLK);
    chk("rst cyc2", {27'b0, LD, AD, SH, DONE, BUSY}, 0);
    RST = 1'b0; ST = 1'b0;
    @(negedge CLK);
    chk("rst release idle", {27'b0, LD, AD, SH, DONE, BUSY}, 0);

    // 0 x 10: no adds, 9 cycles.
    run_op("zero", 4'b0000, 4'b1010, 0, 0, 9, 0, 8'h00);
    // 11 x 13 = 143.
    run_op("b1011", 4'b1011, 4'b1101, 0, 0, 12, 3, 8'h8F);
    // 15 x 15 = 225, ST held through DONE.
    run_op("all1_hold", 4'b1111, 4'b1111, 1, 0, 13, 4, 8'hE1);

    // Reset during the third SHIFT.
    op_mp = 4'b0110; op_mc = 4'b0101;
    @(negedge CLK); ST = 1'b1;
    @(negedge CLK); ST = 1'b0;
    nsh = 0; guard = 0;
    while (nsh < 3 && guard < 40) begin
      @(negedge CLK);
      guard++;
      if (SH) nsh++;
    end
    chk("rst_mid reached 3rd shift", nsh, 3);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid outputs", {27'b0, LD, AD, SH, DONE, BUSY}, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid idle", {27'b0, LD, AD, SH, DONE, BUSY}, 0);
    // Fresh operation after mid-op reset: 5 x 3 = 15.
    run_op("after_rst", 4'b0101, 4'b0011, 0, 0, 11, 2, 8'h0F);

    // ST toggling while busy and M=1 outside EVAL: 9 x 7 = 63.
    run_op("wiggle", 4'b1001, 4'b0111, 0, 1, 11, 2, 8'h3F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
